// File: rtl/vip_bbox_detect_pkg.sv
// Shared types and constants for the VIP bounding-box stage.
// Holds default image geometry, coordinate/count widths, the frame timing
// constants shared with the erosion benches, and a saturating count helper.
package vip_bbox_detect_pkg;

  localparam int unsigned DEF_HDISP = 640;
  localparam int unsigned DEF_VDISP = 480;
  localparam int unsigned COORD_W   = 11;
  localparam int unsigned CNT_W     = 20;

  // Frame timing: 640 + 15 = 655 clocks per line, 480 + 2 = 482 lines per frame.
  localparam int unsigned H_SYNC  = 1;
  localparam int unsigned H_BACK  = 7;
  localparam int unsigned H_FRONT = 7;
  localparam int unsigned V_SYNC  = 1;
  localparam int unsigned V_FRONT = 1;
  localparam int unsigned H_TOTAL = DEF_HDISP + H_SYNC + H_BACK + H_FRONT;
  localparam int unsigned V_TOTAL = DEF_VDISP + V_SYNC + V_FRONT;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef struct packed {
    coord_t xmin;
    coord_t xmax;
    coord_t ymin;
    coord_t ymax;
  } box_t;

  // Empty box: min at all-ones and max at zero, so the first hit sets both.
  localparam box_t BOX_EMPTY = '{xmin: '1, xmax: '0, ymin: '1, ymax: '0};

  function automatic cnt_t cnt_sat_inc(input cnt_t c);
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/vip_bbox_detect_if.sv
// 1-bit video mask stream: vsync (frame valid), href (line valid),
// clken (pixel qualifier), img_bit (mask pixel, 1 = foreground).
// master drives the stream, slave consumes it.
interface vip_bbox_detect_if;
  logic vsync;
  logic href;
  logic clken;
  logic img_bit;

  modport master (output vsync, output href, output clken, output img_bit);
  modport slave  (input vsync, input href, input clken, input img_bit);
endinterface

// File: rtl/vip_sync_edge.sv
// Registers vsync/href once and derives edge pulses from them.
// Ports: clk, rst_n (async active-low); vsync, href in;
//        vsync_r, href_r (1-clk delayed copies); vsync_rise, vsync_fall, href_fall pulses.
// Edges are suppressed on the first clock after reset so that a reset released
// in the middle of a frame does not look like a frame start.
module vip_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  input  logic href,
  output logic vsync_r,
  output logic href_r,
  output logic vsync_rise,
  output logic vsync_fall,
  output logic href_fall
);

  logic primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_r <= 1'b0;
      href_r  <= 1'b0;
      primed  <= 1'b0;
    end else begin
      vsync_r <= vsync;
      href_r  <= href;
      primed  <= 1'b1;
    end
  end

  assign vsync_rise = primed & vsync & ~vsync_r;
  assign vsync_fall = primed & vsync_r & ~vsync;
  assign href_fall  = primed & href_r & ~href;

endmodule

// File: rtl/vip_bbox_detect.sv
// Per-frame bounding box and foreground count of a 1-bit motion mask.
// Ports: sys_clk, sys_rst_n (async active-low); per_frame (slave) mask stream in;
//        post_frame (master) stream out, 1 clk later, with the last latched box
//        border drawn in; box_valid 1-clk pulse when results update; box_found,
//        box_xmin/xmax/ymin/ymax, box_pix_cnt latched results held until the next frame end.
module vip_bbox_detect
  import vip_bbox_detect_pkg::*;
#(
  parameter int unsigned IMG_HDISP  = DEF_HDISP,
  parameter int unsigned IMG_VDISP  = DEF_VDISP,
  parameter int unsigned MIN_PIX    = 16,
  parameter bit          OVERLAY_EN = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  vip_bbox_detect_if.slave  per_frame,
  vip_bbox_detect_if.master post_frame,
  output logic              box_valid,
  output logic              box_found,
  output coord_t            box_xmin,
  output coord_t            box_xmax,
  output coord_t            box_ymin,
  output coord_t            box_ymax,
  output cnt_t              box_pix_cnt
);

  localparam coord_t XLAST   = coord_t'(IMG_HDISP - 1);
  localparam coord_t YLIM    = coord_t'(IMG_VDISP);
  localparam cnt_t   MIN_CNT = cnt_t'(MIN_PIX);

  logic vsync_r, href_r, vsync_rise, vsync_fall, href_fall;

  vip_sync_edge u_sync_edge (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .vsync      (per_frame.vsync),
    .href       (per_frame.href),
    .vsync_r    (vsync_r),
    .href_r     (href_r),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .href_fall  (href_fall)
  );

  logic   armed_q, line_full_q, line_full_d;
  coord_t x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  cnt_t   cnt_q, cnt_d;
  box_t   acc_q, acc_d;
  logic   pix_ev, hit, latch, found_d;
  logic   clken_q, bit_q;
  logic   on_col, on_row, border;

  // line_full marks that column IMG_HDISP-1 was already consumed, so extra
  // pixels on an over-long line are dropped instead of piling onto the last column.
  assign pix_ev = per_frame.href & per_frame.clken & armed_q & ~line_full_q;
  assign hit    = pix_ev & per_frame.img_bit & (x_cnt_q <= XLAST) & (y_cnt_q < YLIM);

  always_comb begin
    x_cnt_d     = x_cnt_q;
    y_cnt_d     = y_cnt_q;
    line_full_d = line_full_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    if (vsync_rise) begin
      x_cnt_d     = '0;
      y_cnt_d     = '0;
      line_full_d = 1'b0;
      cnt_d       = '0;
      acc_d       = BOX_EMPTY;
    end else begin
      if (pix_ev) begin
        if (x_cnt_q == XLAST) line_full_d = 1'b1;
        else                  x_cnt_d     = x_cnt_q + 1'b1;
      end
      if (hit) begin
        cnt_d = cnt_sat_inc(cnt_q);
        if (x_cnt_q < acc_q.xmin) acc_d.xmin = x_cnt_q;
        if (x_cnt_q > acc_q.xmax) acc_d.xmax = x_cnt_q;
        if (y_cnt_q < acc_q.ymin) acc_d.ymin = y_cnt_q;
        if (y_cnt_q > acc_q.ymax) acc_d.ymax = y_cnt_q;
      end
      if (href_fall) begin
        x_cnt_d     = '0;
        line_full_d = 1'b0;
        if (y_cnt_q != YLIM) y_cnt_d = y_cnt_q + 1'b1;
      end
    end
  end

  // Latch from the next-state values so a pixel coinciding with frame end is included.
  assign latch   = vsync_fall & armed_q;
  assign found_d = (cnt_d >= MIN_CNT);

  assign on_col = ((x_cnt_q == box_xmin) || (x_cnt_q == box_xmax)) &&
                  (box_ymin <= y_cnt_q) && (y_cnt_q <= box_ymax);
  assign on_row = ((y_cnt_q == box_ymin) || (y_cnt_q == box_ymax)) &&
                  (box_xmin <= x_cnt_q) && (x_cnt_q <= box_xmax);
  assign border = OVERLAY_EN & box_found & per_frame.href & (on_col | on_row);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      armed_q     <= 1'b0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      line_full_q <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      clken_q     <= 1'b0;
      bit_q       <= 1'b0;
      box_valid   <= 1'b0;
      box_found   <= 1'b0;
      box_xmin    <= '0;
      box_xmax    <= '0;
      box_ymin    <= '0;
      box_ymax    <= '0;
      box_pix_cnt <= '0;
    end else begin
      armed_q     <= armed_q | vsync_rise;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      line_full_q <= line_full_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      clken_q     <= per_frame.clken;
      bit_q       <= per_frame.img_bit | border;
      box_valid   <= latch;
      if (latch) begin
        box_found   <= found_d;
        box_pix_cnt <= cnt_d;
        box_xmin    <= found_d ? acc_d.xmin : '0;
        box_xmax    <= found_d ? acc_d.xmax : '0;
        box_ymin    <= found_d ? acc_d.ymin : '0;
        box_ymax    <= found_d ? acc_d.ymax : '0;
      end
    end
  end

  assign post_frame.vsync   = vsync_r;
  assign post_frame.href    = href_r;
  assign post_frame.clken   = clken_q;
  assign post_frame.img_bit = bit_q;

endmodule

// File: tb/tb_vip_bbox_detect.sv
// Bench for vip_bbox_detect on a reduced 16x12 image. Two instances share the
// input stream: MIN_PIX=16 and MIN_PIX=1. A frame-level reference model predicts
// every output each cycle; literal expectations pin known frames.
module tb_vip_bbox_detect;
  import vip_bbox_detect_pkg::*;

  localparam int H = 16;
  localparam int V = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vip_bbox_detect_if per_if ();
  vip_bbox_detect_if post_if0 ();
  vip_bbox_detect_if post_if1 ();

  logic   bv0, bf0, bv1, bf1;
  coord_t xa0, xb0, ya0, yb0, xa1, xb1, ya1, yb1;
  cnt_t   pc0, pc1;

  vip_bbox_detect #(.IMG_HDISP(H), .IMG_VDISP(V), .MIN_PIX(16), .OVERLAY_EN(1'b1)) u_dut0 (
    .sys_clk (clk), .sys_rst_n (rst_n), .per_frame (per_if), .post_frame (post_if0),
    .box_valid (bv0), .box_found (bf0), .box_xmin (xa0), .box_xmax (xb0),
    .box_ymin (ya0), .box_ymax (yb0), .box_pix_cnt (pc0)
  );

  vip_bbox_detect #(.IMG_HDISP(H), .IMG_VDISP(V), .MIN_PIX(1), .OVERLAY_EN(1'b1)) u_dut1 (
    .sys_clk (clk), .sys_rst_n (rst_n), .per_frame (per_if), .post_frame (post_if1),
    .box_valid (bv1), .box_found (bf1), .box_xmin (xa1), .box_xmax (xb1),
    .box_ymin (ya1), .box_ymax (yb1), .box_pix_cnt (pc1)
  );

  // Layout: post v,h,c,b [69:66], valid [65], found [64], xmin, xmax, ymin, ymax, cnt [19:0].
  logic [69:0] act [2];
  assign act[0] = {post_if0.vsync, post_if0.href, post_if0.clken, post_if0.img_bit,
                   bv0, bf0, xa0, xb0, ya0, yb0, pc0};
  assign act[1] = {post_if1.vsync, post_if1.href, post_if1.clken, post_if1.img_bit,
                   bv1, bf1, xa1, xb1, ya1, yb1, pc1};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [69:0] got, input logic [69:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  int minp [2] = '{16, 1};
  bit pval [2], pv [2], ph [2], armed [2];
  int n [2], m [2], cnt [2], ax0 [2], ax1 [2], ay0 [2], ay1 [2];
  bit e_v [2], e_h [2], e_c [2], e_b [2], lv [2], lf [2];
  int lx0 [2], lx1 [2], ly0 [2], ly1 [2], lc [2];
  int tag_x = -1, tag_y = -1, et_x = -1, et_y = -1;

  task automatic model_reset(input int k);
    pval[k] = 0; pv[k] = 0; ph[k] = 0; armed[k] = 0;
    n[k] = 0; m[k] = 0; cnt[k] = 0; ax0[k] = 0; ax1[k] = 0; ay0[k] = 0; ay1[k] = 0;
    e_v[k] = 0; e_h[k] = 0; e_c[k] = 0; e_b[k] = 0; lv[k] = 0; lf[k] = 0;
    lx0[k] = 0; lx1[k] = 0; ly0[k] = 0; ly1[k] = 0; lc[k] = 0;
  endtask

  task automatic model_step(input int k);
    bit v, h, c, b, rise, fall, hfall, bord;
    int xc, yc;
    v = per_if.vsync; h = per_if.href; c = per_if.clken; b = per_if.img_bit;
    rise  = pval[k] && v && !pv[k];
    fall  = pval[k] && !v && pv[k];
    hfall = pval[k] && ph[k] && !h;
    // Position of the current pixel as reported by the spec's saturating counters.
    xc = (n[k] < H - 1) ? n[k] : H - 1;
    yc = (m[k] < V) ? m[k] : V;
    bord = lf[k] && h &&
           (((xc == lx0[k] || xc == lx1[k]) && ly0[k] <= yc && yc <= ly1[k]) ||
            ((yc == ly0[k] || yc == ly1[k]) && lx0[k] <= xc && xc <= lx1[k]));
    e_v[k] = v; e_h[k] = h; e_c[k] = c; e_b[k] = b | bord;
    if (rise) begin
      armed[k] = 1; n[k] = 0; m[k] = 0; cnt[k] = 0;
      ax0[k] = 2047; ax1[k] = 0; ay0[k] = 2047; ay1[k] = 0;
    end else begin
      if (h && c && armed[k] && n[k] < H) begin
        if (b && m[k] < V) begin
          if (cnt[k] < (1 << 20) - 1) cnt[k]++;
          if (n[k] < ax0[k]) ax0[k] = n[k];
          if (n[k] > ax1[k]) ax1[k] = n[k];
          if (m[k] < ay0[k]) ay0[k] = m[k];
          if (m[k] > ay1[k]) ay1[k] = m[k];
        end
        n[k]++;
      end
      if (hfall) begin
        n[k] = 0;
        if (m[k] < V) m[k]++;
      end
    end
    lv[k] = fall && armed[k];
    if (lv[k]) begin
      lf[k]  = (cnt[k] >= minp[k]);
      lc[k]  = cnt[k];
      lx0[k] = lf[k] ? ax0[k] : 0;
      lx1[k] = lf[k] ? ax1[k] : 0;
      ly0[k] = lf[k] ? ay0[k] : 0;
      ly1[k] = lf[k] ? ay1[k] : 0;
    end
    pv[k] = v; ph[k] = h; pval[k] = 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
      et_x = -1; et_y = -1;
    end else begin
      model_step(0);
      model_step(1);
      et_x = tag_x; et_y = tag_y;
    end
  end

  function automatic logic [69:0] exp_vec(input int k);
    return {e_v[k], e_h[k], e_c[k], e_b[k], lv[k], lf[k], coord_t'(lx0[k]), coord_t'(lx1[k]),
            coord_t'(ly0[k]), coord_t'(ly1[k]), cnt_t'(lc[k])};
  endfunction

  // ---------------- per-cycle compare ----------------
  int vcnt [2];
  bit ovl_chk = 0;
  int ovl_hits = 0;
  int lit_x [5] = '{4, 6, 9, 6, 0};
  int lit_y [5] = '{5, 3, 7, 5, 0};
  int lit_b [5] = '{1, 1, 1, 0, 0};

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cycle0", act[0], exp_vec(0));
      chk("cycle1", act[1], exp_vec(1));
      if (act[0][65]) vcnt[0]++;
      if (act[1][65]) vcnt[1]++;
      if (ovl_chk) begin
        for (int i = 0; i < 5; i++) begin
          if (et_x == lit_x[i] && et_y == lit_y[i]) begin
            chk($sformatf("overlay(%0d,%0d)", lit_x[i], lit_y[i]), 70'(act[0][66]),
                70'(lit_b[i]));
            ovl_hits++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  bit rnd_mask [V][H];

  function automatic bit pat(input int kind, input int x, input int y);
    case (kind)
      1:       return (x >= 4 && x <= 9 && y >= 3 && y <= 7);
      2:       return 1'b1;
      3:       return (x == 1 && y == 1) || (x == 8 && y == 6) || (x == 14 && y == 10);
      4:       return (x == H - 1 && y == V - 1);
      5:       return rnd_mask[y][x];
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // late=1 drops vsync on the last pixel of the frame; rel_line>=0 releases reset there.
  task automatic run_frame(input int kind, input bit late, input int rel_line);
    int px, miss;
    bit c;
    vcnt[0] = 0; vcnt[1] = 0;
    per_if.vsync = 1'b1; per_if.href = 1'b0; per_if.clken = 1'b0; per_if.img_bit = 1'b0;
    idle(3);
    for (int y = 0; y < V; y++) begin
      if (rel_line == y) rst_n = 1'b1;
      per_if.href = 1'b1;
      px = 0; miss = 0;
      while (px < H) begin
        c = (($urandom % 4) != 0) || (miss >= 2);
        per_if.clken = c;
        if (c) begin
          per_if.img_bit = pat(kind, px, y);
          tag_x = px; tag_y = y;
          if (late && y == V - 1 && px == H - 1) per_if.vsync = 1'b0;
          px++; miss = 0;
        end else begin
          per_if.img_bit = 1'($urandom % 2);
          tag_x = -1; tag_y = -1;
          miss++;
        end
        @(negedge clk);
      end
      per_if.href = 1'b0; per_if.img_bit = 1'b0; tag_x = -1; tag_y = -1;
      per_if.clken = 1'($urandom % 2);
      idle(3);
      per_if.clken = 1'b0;
    end
    per_if.vsync = 1'b0;
    idle(6);
  endtask

  task automatic chk_box(input int k, input string name, input int pulses, input bit found,
                         input int x0, input int x1, input int y0, input int y1, input int c);
    chk({name, "_pulses"}, 70'(vcnt[k]), 70'(pulses));
    chk({name, "_result"}, {5'b0, act[k][64:0]},
        {5'b0, 1'b0, found, coord_t'(x0), coord_t'(x1), coord_t'(y0), coord_t'(y1), cnt_t'(c)});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    per_if.vsync = 1'b0; per_if.href = 1'b0; per_if.clken = 1'b0; per_if.img_bit = 1'b0;
    vcnt[0] = 0; vcnt[1] = 0;
    idle(2);
    chk("reset0", act[0], 70'd0);
    chk("reset1", act[1], 70'd0);
    rst_n = 1'b1;
    idle(4);

    run_frame(0, 0, -1);
    chk_box(0, "zero0", 1, 0, 0, 0, 0, 0, 0);
    chk_box(1, "zero1", 1, 0, 0, 0, 0, 0, 0);

    run_frame(1, 0, -1);
    chk_box(0, "rect0", 1, 1, 4, 9, 3, 7, 30);
    chk_box(1, "rect1", 1, 1, 4, 9, 3, 7, 30);

    ovl_chk = 1'b1;
    run_frame(0, 0, -1);
    ovl_chk = 1'b0;
    chk("overlay_hits", 70'(ovl_hits), 70'd5);

    run_frame(2, 1, -1);
    chk_box(0, "ones0", 1, 1, 0, H - 1, 0, V - 1, H * V);

    run_frame(3, 0, -1);
    chk_box(0, "three0", 1, 0, 0, 0, 0, 0, 3);
    chk_box(1, "three1", 1, 1, 1, 14, 1, 10, 3);
    run_frame(0, 0, -1);

    // Reset released mid-frame: that frame must not report.
    rst_n = 1'b0;
    #1;
    chk("midreset0", act[0], 70'd0);
    chk("midreset1", act[1], 70'd0);
    run_frame(1, 0, 6);
    chk("midreset_pulses0", 70'(vcnt[0]), 70'd0);
    chk("midreset_pulses1", 70'(vcnt[1]), 70'd0);

    run_frame(4, 0, -1);
    chk_box(0, "corner0", 1, 0, 0, 0, 0, 0, 1);
    chk_box(1, "corner1", 1, 1, H - 1, H - 1, V - 1, V - 1, 1);

    for (int r = 0; r < 5; r++) begin
      int thr;
      thr = $urandom_range(1, 8);
      for (int y = 0; y < V; y++)
        for (int x = 0; x < H; x++)
          rnd_mask[y][x] = (($urandom % thr) == 0);
      run_frame(5, r[0], -1);
      chk("rand_pulses0", 70'(vcnt[0]), 70'd1);
    end

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
